// File: rtl/bcd_display_mux_if.sv
// rtl/bcd_display_mux_if.sv - display-side bundle for bcd_display_mux
//
// Purpose: groups the digit inputs and the multiplexed display outputs.
// Ports (signals):
//   en          display enable, 0 blanks the display
//   bcd         packed BCD digits, digit k = bcd[4k+3:4k], k=0 is units
//   dp_in       decimal point request per digit
//   seg         segments {g,f,e,d,c,b,a}
//   dp          decimal point of the active digit
//   an          one-hot digit select
//   frame_tick  one-cycle pulse at the start of each scan frame
// Modports: master drives the digits, slave is the display multiplexer.
interface bcd_display_mux_if #(
   parameter int NUM_DIGITS = 4
);
   logic                    en;
   logic [4*NUM_DIGITS-1:0] bcd;
   logic [NUM_DIGITS-1:0]   dp_in;
   logic [6:0]              seg;
   logic                    dp;
   logic [NUM_DIGITS-1:0]   an;
   logic                    frame_tick;

   modport master (
      output en, bcd, dp_in,
      input  seg, dp, an, frame_tick
   );

   modport slave (
      input  en, bcd, dp_in,
      output seg, dp, an, frame_tick
   );
endinterface

// File: rtl/bcd_display_mux.sv
// rtl/bcd_display_mux.sv - time-multiplexed BCD to 7-segment display driver
//
// Purpose: scans NUM_DIGITS BCD digits onto a multiplexed 7-segment display.
// A prescaler holds each digit for PRESCALE cycles; the digit inputs are
// captured into a shadow register once per frame so a frame never tears.
// Optional build macro: DISP_LZB_EN enables leading-zero blanking.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  bcd_display_mux_if.slave (en, bcd, dp_in in; seg, dp, an, frame_tick out)
module bcd_display_mux #(
   parameter int NUM_DIGITS = 4,
   parameter int PRESCALE   = 50000,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input logic               clk,
   input logic               rst,
   bcd_display_mux_if.slave  bus
);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CW = $clog2(PRESCALE);

   logic [CW-1:0]           cnt;
   logic [IW-1:0]           idx;
   logic [4*NUM_DIGITS-1:0] sh_bcd;
   logic [NUM_DIGITS-1:0]   sh_dp;
   logic [6:0]              seg_q;
   logic                    dp_q;
   logic [NUM_DIGITS-1:0]   an_q;
   logic                    tick_q;

   logic                    digit_end;
   logic                    frame_end;
   logic [3:0]              cur_digit;
   logic                    cur_dp;
   logic [NUM_DIGITS-1:0]   cur_onehot;
   logic                    cur_blank;
   logic [6:0]              cur_seg;

   function automatic logic [6:0] decode(input logic [3:0] v);
      case (v)
         4'd0:    decode = 7'b0111111;
         4'd1:    decode = 7'b0000110;
         4'd2:    decode = 7'b1011011;
         4'd3:    decode = 7'b1001111;
         4'd4:    decode = 7'b1100110;
         4'd5:    decode = 7'b1101101;
         4'd6:    decode = 7'b1111101;
         4'd7:    decode = 7'b0000111;
         4'd8:    decode = 7'b1111111;
         4'd9:    decode = 7'b1101111;
         default: decode = 7'b0000000;
      endcase
   endfunction

   assign digit_end = (cnt == CW'(PRESCALE - 1));
   assign frame_end = digit_end && (idx == IW'(NUM_DIGITS - 1));

   // Select the active digit from the shadow copy, never the live inputs.
   always_comb begin
      cur_digit  = 4'd0;
      cur_dp     = 1'b0;
      cur_onehot = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx == IW'(k)) begin
            cur_digit     = sh_bcd[4*k +: 4];
            cur_dp        = sh_dp[k];
            cur_onehot[k] = 1'b1;
         end
      end
   end

`ifdef DISP_LZB_EN
   logic [NUM_DIGITS-1:0] lz_mask;
   logic                  upper_zero;

   // Walk from the most significant digit down; a digit is a leading zero
   // while it and everything above it is zero. Digit 0 always stays lit.
   always_comb begin
      lz_mask    = '0;
      upper_zero = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         upper_zero = upper_zero && (sh_bcd[4*k +: 4] == 4'd0);
         lz_mask[k] = upper_zero && (k != 0);
      end
      cur_blank = |(lz_mask & cur_onehot);
   end
`else
   assign cur_blank = 1'b0;
`endif

   assign cur_seg = cur_blank ? 7'b0000000 : decode(cur_digit);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= '0;
         idx    <= '0;
         sh_bcd <= '0;
         sh_dp  <= '0;
         tick_q <= 1'b0;
         seg_q  <= {7{ACTIVE_LOW}};
         dp_q   <= ACTIVE_LOW;
         an_q   <= {NUM_DIGITS{ACTIVE_LOW}};
      end else begin
         tick_q <= frame_end;
         if (digit_end) begin
            cnt <= '0;
            idx <= frame_end ? '0 : idx + 1'b1;
         end else begin
            cnt <= cnt + 1'b1;
         end
         if (frame_end) begin
            sh_bcd <= bus.bcd;
            sh_dp  <= bus.dp_in;
         end
         if (bus.en) begin
            seg_q <= {7{ACTIVE_LOW}} ^ cur_seg;
            dp_q  <= ACTIVE_LOW ^ cur_dp;
            an_q  <= {NUM_DIGITS{ACTIVE_LOW}} ^ cur_onehot;
         end else begin
            seg_q <= {7{ACTIVE_LOW}};
            dp_q  <= ACTIVE_LOW;
            an_q  <= {NUM_DIGITS{ACTIVE_LOW}};
         end
      end
   end

   assign bus.seg        = seg_q;
   assign bus.dp         = dp_q;
   assign bus.an         = an_q;
   assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_bcd_display_mux.sv
// tb/tb_bcd_display_mux.sv - randomized self-checking bench for bcd_display_mux
module tb_bcd_display_mux;
   localparam int N  = 4;
   localparam int P  = 4;
   localparam int FR = N * P;
   localparam int HMAX = 4096;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;
   int   t = 0;

   logic [15:0] h_bcd [HMAX];
   logic [3:0]  h_dp  [HMAX];
   logic        h_en  [HMAX];

   logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};

   bcd_display_mux_if #(.NUM_DIGITS(N)) bus_l ();
   bcd_display_mux_if #(.NUM_DIGITS(N)) bus_h ();

   bcd_display_mux #(.NUM_DIGITS(N), .PRESCALE(P), .ACTIVE_LOW(1'b1)) dut_l (
      .clk (clk),
      .rst (rst),
      .bus (bus_l.slave)
   );

   bcd_display_mux #(.NUM_DIGITS(N), .PRESCALE(P), .ACTIVE_LOW(1'b0)) dut_h (
      .clk (clk),
      .rst (rst),
      .bus (bus_h.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s t=%0d: got %h expected %h", tag, t, obs, exp);
      end
   endtask

   task automatic set_inputs(input logic e, input logic [15:0] b, input logic [3:0] d);
      bus_l.en = e;  bus_l.bcd = b;  bus_l.dp_in = d;
      bus_h.en = e;  bus_h.bcd = b;  bus_h.dp_in = d;
   endtask

   // Expected outputs after the t-th edge since reset, from the timing rules:
   // the digit shown lags the scan position by one edge, and the shadow holds
   // whatever was sampled on the most recent frame-boundary edge.
   task automatic check_cycle();
      logic [3:0]  e_an, h_an;
      logic [6:0]  e_seg, h_seg;
      logic        e_dp, h_dpv, e_ft;
      logic [15:0] sb;
      logic [3:0]  sd, v;
      int          d, s;
      if (t == 0) begin
         e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_ft = 1'b0;
      end else begin
         d    = ((t - 1) / P) % N;
         s    = ((t - 1) / FR) * FR;
         sb   = (s > 0) ? h_bcd[s] : 16'h0;
         sd   = (s > 0) ? h_dp[s] : 4'h0;
         e_ft = ((t % FR) == 0);
         if (!h_en[t]) begin
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
         end else begin
            v     = 4'((sb >> (4 * d)) & 16'hF);
            e_seg = ~seg_tab[v];
`ifdef DISP_LZB_EN
            if (d > 0 && (sb >> (4 * d)) == 16'h0) e_seg = 7'h7F;
`endif
            e_an = ~(4'b0001 << d);
            e_dp = ~sd[d];
         end
      end
      h_an  = ~e_an;
      h_seg = ~e_seg;
      h_dpv = ~e_dp;
      check("an_low",      16'(bus_l.an),         16'(e_an));
      check("seg_low",     16'(bus_l.seg),        16'(e_seg));
      check("dp_low",      16'(bus_l.dp),         16'(e_dp));
      check("tick_low",    16'(bus_l.frame_tick), 16'(e_ft));
      check("an_high",     16'(bus_h.an),         16'(h_an));
      check("seg_high",    16'(bus_h.seg),        16'(h_seg));
      check("dp_high",     16'(bus_h.dp),         16'(h_dpv));
      check("tick_high",   16'(bus_h.frame_tick), 16'(e_ft));
   endtask

   // One clock: inputs are already stable, record them at the edge, check on
   // the following falling edge.
   task automatic step();
      @(posedge clk);
      if (rst) begin
         t = 0;
      end else if (t < HMAX - 1) begin
         t++;
         h_bcd[t] = bus_l.bcd;
         h_dp[t]  = bus_l.dp_in;
         h_en[t]  = bus_l.en;
      end
      @(negedge clk);
      check_cycle();
   endtask

   function automatic logic [15:0] rand_bcd();
      logic [15:0] b;
      for (int k = 0; k < 4; k++)
         b[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      return b;
   endfunction

   initial begin
      logic        e;
      logic [15:0] b;
      logic [3:0]  d;
      bit          did_rst;
      did_rst = 1'b0;
      set_inputs(1'b1, 16'h1234, 4'h0);
      rst = 1'b1;
      @(negedge clk);
      repeat (3) step();
      rst = 1'b0;

      set_inputs(1'b1, 16'h9071, 4'b0100);
      repeat (40) step();

      e = 1'b1; b = 16'h1111; d = 4'h0;
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 7) == 0) b = rand_bcd();
         if ($urandom_range(0, 7) == 0) d = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 19) == 0) e = ~e;
         if (c < 200) e = 1'b1;
         // Reset lands exactly on a frame-boundary edge.
         rst = (!did_rst && c > 700 && (t % FR) == FR - 1);
         if (rst) did_rst = 1'b1;
         set_inputs(e, b, d);
         step();
      end
      rst = 1'b0;
      set_inputs(1'b1, 16'h0000, 4'h1);
      repeat (40) step();
      set_inputs(1'b1, 16'h0050, 4'h0);
      repeat (40) step();
      set_inputs(1'b1, 16'hF00A, 4'b0010);
      repeat (40) step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
